vending_machine_mt: RTL

Parametrised multi-tray vending controller, next generation of the single-config vending block. Supports N trays with per-tray prices and stock depth set by parameters, credit saturation, a timed dispense pulse, and a cancel/refund state machine that returns change as quarter-unit pulses. Sits between the coin/keypad front-end (raw level inputs, edge-detected here) and the tray actuator and display logic.

---
 rtl/vending_machine_mt_if.sv | 32 +++
 rtl/vending_machine_mt.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vending_machine_mt_if.sv
// Bundles the front-end level inputs and the actuator/display outputs of
// the multi-tray vending controller. The controller takes the slave side.
interface vending_machine_mt_if #(
    parameter int NUM_TRAYS = 4,
    parameter int CREDIT_W  = 12
);
    logic                 quarter;
    logic                 dollar;
    logic [NUM_TRAYS-1:0] select;
    logic                 buy;
    logic                 cancel;
    logic [NUM_TRAYS-1:0] load;
    logic [CREDIT_W-1:0]  credit;
    logic [NUM_TRAYS-1:0] dispense;
    logic                 change_pulse;
    logic                 coin_reject;
    logic                 vend_fail;
    logic [NUM_TRAYS-1:0] out_of_stock;
    logic                 busy;

    modport master (
        output quarter, dollar, select, buy, cancel, load,
        input  credit, dispense, change_pulse, coin_reject, vend_fail,
               out_of_stock, busy
    );

    modport slave (
        input  quarter, dollar, select, buy, cancel, load,
        output credit, dispense, change_pulse, coin_reject, vend_fail,
               out_of_stock, busy
    );
endinterface

// File: rtl/vending_machine_mt.sv
// Multi-tray vending controller: edge-detects coin/keypad levels, keeps a
// saturating credit, per-tray stock counters, a timed dispense pulse and a
// refund sequence that pays change back as one pulse per 25 units.
module vending_machine_mt #(
    parameter int                          NUM_TRAYS       = 4,
    parameter int                          STOCK_W         = 4,
    parameter int                          CREDIT_W        = 12,
    parameter logic [NUM_TRAYS*CREDIT_W-1:0] PRICES        = {12'd200, 12'd150, 12'd75, 12'd25},
    parameter int                          DISPENSE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    vending_machine_mt_if.slave vm_if
);

    typedef enum logic [1:0] {S_IDLE, S_DISPENSE, S_REFUND} state_e;

    localparam int                  CNT_W      = $clog2(DISPENSE_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DISPENSE_CYCLES - 1);
    localparam logic [STOCK_W-1:0]  STOCK_FULL = '1;
    localparam logic [CREDIT_W:0]   CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W:0]   QUARTER_V  = (CREDIT_W + 1)'(25);
    localparam logic [CREDIT_W:0]   DOLLAR_V   = (CREDIT_W + 1)'(100);

    // Registered state and its next-state values
    state_e               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [STOCK_W-1:0]   stock_q [NUM_TRAYS];
    logic [STOCK_W-1:0]   stock_d [NUM_TRAYS];
    logic [NUM_TRAYS-1:0] dispense_q, dispense_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 vend_fail_q, vend_fail_d;
    logic [NUM_TRAYS-1:0] oos_q, oos_d;
    logic [3:0]           prev_q;           // {cancel, buy, dollar, quarter}

    // Edge detection and purchase qualification
    logic [3:0]           raw_in;
    logic [3:0]           edge_in;
    logic                 quarter_edge, dollar_edge, buy_edge, cancel_edge, coin_any;
    logic [CREDIT_W:0]    coin_sum, credit_sum;
    logic                 coin_ok;
    logic [CREDIT_W-1:0]  price_sel;
    logic [STOCK_W-1:0]   stock_sel;
    logic                 buy_ok;

    assign raw_in       = {vm_if.cancel, vm_if.buy, vm_if.dollar, vm_if.quarter};
    assign edge_in      = raw_in & ~prev_q;
    assign quarter_edge = edge_in[0];
    assign dollar_edge  = edge_in[1];
    assign buy_edge     = edge_in[2];
    assign cancel_edge  = edge_in[3];
    assign coin_any     = quarter_edge | dollar_edge;

    assign coin_sum   = (quarter_edge ? QUARTER_V : '0) + (dollar_edge ? DOLLAR_V : '0);
    assign credit_sum = {1'b0, credit_q} + coin_sum;
    assign coin_ok    = (credit_sum <= CREDIT_MAX);

    // Look up price and stock of the selected tray (only meaningful when one-hot)
    always_comb begin
        price_sel = '0;
        stock_sel = '0;
        for (int i = 0; i < NUM_TRAYS; i++) begin
            if (vm_if.select[i]) begin
                price_sel = PRICES[i*CREDIT_W +: CREDIT_W];
                stock_sel = stock_q[i];
            end
        end
    end

    assign buy_ok = $onehot(vm_if.select) && (stock_sel != '0) && (credit_q >= price_sel);

    // State register: all sequential state, synchronous active-high reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before this edge, independent of statement order.
        if (reset) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            dispense_q    <= '0;
            cnt_q         <= '0;
            coin_reject_q <= 1'b0;
            vend_fail_q   <= 1'b0;
            oos_q         <= '0;
            prev_q        <= '1;    // levels held high through reset give no edge
            // NOTE: the stock array is real machine state (not a storage memory),
            // so it is reset explicitly to full.
            for (int i = 0; i < NUM_TRAYS; i++) stock_q[i] <= STOCK_FULL;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            dispense_q    <= dispense_d;
            cnt_q         <= cnt_d;
            coin_reject_q <= coin_reject_d;
            vend_fail_q   <= vend_fail_d;
            oos_q         <= oos_d;
            prev_q        <= raw_in;
            for (int i = 0; i < NUM_TRAYS; i++) stock_q[i] <= stock_d[i];
        end
    end

    // Next-state logic: transitions plus credit, stock and pulse updates
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        credit_d      = credit_q;
        dispense_d    = dispense_q;
        cnt_d         = cnt_q;
        coin_reject_d = 1'b0;
        vend_fail_d   = 1'b0;
        for (int i = 0; i < NUM_TRAYS; i++) stock_d[i] = stock_q[i];

        case (state_q)
            S_IDLE: begin
                if (cancel_edge) begin
                    if (credit_q != '0) state_d = S_REFUND;
                    coin_reject_d = coin_any;
                end else if (coin_any) begin
                    if (coin_ok) credit_d      = credit_sum[CREDIT_W-1:0];
                    else         coin_reject_d = 1'b1;
                end else if (buy_edge) begin
                    if (buy_ok) begin
                        credit_d   = credit_q - price_sel;
                        dispense_d = vm_if.select;
                        cnt_d      = '0;
                        state_d    = S_DISPENSE;
                        for (int i = 0; i < NUM_TRAYS; i++)
                            if (vm_if.select[i]) stock_d[i] = stock_q[i] - STOCK_W'(1);
                    end else begin
                        vend_fail_d = 1'b1;
                    end
                end
            end
            S_DISPENSE: begin
                coin_reject_d = coin_any;
                if (cnt_q == CNT_LAST) begin
                    dispense_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REFUND: begin
                coin_reject_d = coin_any;
                if (credit_q != '0) credit_d = credit_q - QUARTER_V[CREDIT_W-1:0];
                else                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Restock wins over a same-cycle vend decrement
        for (int i = 0; i < NUM_TRAYS; i++)
            if (vm_if.load[i]) stock_d[i] = STOCK_FULL;

        for (int i = 0; i < NUM_TRAYS; i++) oos_d[i] = (stock_q[i] == '0);
    end

    // Output decode from the current state
    always_comb begin
        vm_if.busy         = (state_q != S_IDLE);
        vm_if.change_pulse = (state_q == S_REFUND) && (credit_q != '0);
    end

    assign vm_if.credit       = credit_q;
    assign vm_if.dispense     = dispense_q;
    assign vm_if.coin_reject  = coin_reject_q;
    assign vm_if.vend_fail    = vend_fail_q;
    assign vm_if.out_of_stock = oos_q;

endmodule
